// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod.
// The master drives the controls and observes the count; the slave is the counter.
interface counter_updown_mod_if #(
  parameter int unsigned WIDTH = 8
);
  logic             count_en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_max;
  logic             sat_mode;
  logic             clr_ovf;
  logic [WIDTH-1:0] o_count;
  logic             o_tc;
  logic             o_ovf;
  logic             o_at_max;
  logic             o_at_zero;

  modport master (
    output count_en, up_dn, load, load_val, mod_max, sat_mode, clr_ovf,
    input  o_count, o_tc, o_ovf, o_at_max, o_at_zero
  );

  modport slave (
    input  count_en, up_dn, load, load_val, mod_max, sat_mode, clr_ovf,
    output o_count, o_tc, o_ovf, o_at_max, o_at_zero
  );
endinterface

// File: rtl/counter_updown_mod.sv
// Up/down counter with parallel load, programmable modulus (0..mod_max),
// wrap or saturate boundary handling, terminal-event pulse and sticky overflow.
module counter_updown_mod #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                 clk,
  input  logic                 resetn,
  counter_updown_mod_if.slave  bus
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;

  logic [WIDTH-1:0] w_next_count;
  logic             w_event;
  logic             w_next_ovf;

  // Next count and boundary event; load beats count_en, otherwise hold.
  always_comb begin
    w_next_count = r_count;
    w_event      = 1'b0;
    if (bus.load) begin
      w_next_count = bus.load_val;
    end else if (bus.count_en) begin
      if (bus.up_dn) begin
        if (r_count >= bus.mod_max) begin
          w_event      = 1'b1;
          w_next_count = bus.sat_mode ? bus.mod_max : '0;
        end else begin
          w_next_count = r_count + WIDTH'(1);
        end
      end else begin
        // An out-of-range value is pulled back to mod_max without an event.
        if (r_count > bus.mod_max) begin
          w_next_count = bus.mod_max;
        end else if (r_count == '0) begin
          w_event      = 1'b1;
          w_next_count = bus.sat_mode ? '0 : bus.mod_max;
        end else begin
          w_next_count = r_count - WIDTH'(1);
        end
      end
    end
  end

  // A new event wins over a simultaneous clear.
  assign w_next_ovf = w_event | (r_ovf & ~bus.clr_ovf);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= WIDTH'(RESET_VAL);
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next_count;
      r_tc    <= w_event;
      r_ovf   <= w_next_ovf;
    end
  end

  assign bus.o_count   = r_count;
  assign bus.o_tc      = r_tc;
  assign bus.o_ovf     = r_ovf;
  assign bus.o_at_max  = (r_count >= bus.mod_max);
  assign bus.o_at_zero = (r_count == '0);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: an arithmetic reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_counter_updown_mod;

  logic clk = 1'b0;
  logic resetn_a = 1'b0;
  logic resetn_b = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  counter_updown_mod_if #(.WIDTH(8)) bus_a ();
  counter_updown_mod_if #(.WIDTH(4)) bus_b ();

  counter_updown_mod #(.WIDTH(8), .RESET_VAL(0)) u_a (
    .clk(clk), .resetn(resetn_a), .bus(bus_a.slave)
  );
  counter_updown_mod #(.WIDTH(4), .RESET_VAL(3)) u_b (
    .clk(clk), .resetn(resetn_b), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference rules written as plain integer arithmetic.
  function automatic void mstep(input int cnt, input int ovf, input int rst,
                                input int en, input int ud, input int ld,
                                input int lv, input int mm, input int sat,
                                input int clr, input int rv,
                                output int ncnt, output int ntc, output int novf);
    int ev;
    ev   = 0;
    ncnt = cnt;
    if (rst == 0) begin
      ncnt = rv; ntc = 0; novf = 0;
      return;
    end
    if (ld != 0) ncnt = lv;
    else if (en != 0) begin
      if (ud != 0) begin
        if (cnt >= mm) begin ev = 1; ncnt = (sat != 0) ? mm : 0; end
        else ncnt = cnt + 1;
      end else begin
        if (cnt > mm) ncnt = mm;
        else if (cnt == 0) begin ev = 1; ncnt = (sat != 0) ? 0 : mm; end
        else ncnt = cnt - 1;
      end
    end
    ntc  = ev;
    novf = (ev != 0) ? 1 : ((clr != 0) ? 0 : ovf);
  endfunction

  int ma_cnt = 0, ma_tc = 0, ma_ovf = 0, va = 0;
  int mb_cnt = 0, mb_tc = 0, mb_ovf = 0, vb = 0;

  always @(posedge clk) begin
    int c, t, o;
    mstep(ma_cnt, ma_ovf, int'(resetn_a), int'(bus_a.count_en), int'(bus_a.up_dn),
          int'(bus_a.load), int'(bus_a.load_val), int'(bus_a.mod_max),
          int'(bus_a.sat_mode), int'(bus_a.clr_ovf), 0, c, t, o);
    ma_cnt <= c; ma_tc <= t; ma_ovf <= o;
    if (!resetn_a) va <= 1;
    mstep(mb_cnt, mb_ovf, int'(resetn_b), int'(bus_b.count_en), int'(bus_b.up_dn),
          int'(bus_b.load), int'(bus_b.load_val), int'(bus_b.mod_max),
          int'(bus_b.sat_mode), int'(bus_b.clr_ovf), 3, c, t, o);
    mb_cnt <= c; mb_tc <= t; mb_ovf <= o;
    if (!resetn_b) vb <= 1;
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (va != 0) begin
      check("a_count", int'(bus_a.o_count), ma_cnt);
      check("a_tc", int'(bus_a.o_tc), ma_tc);
      check("a_ovf", int'(bus_a.o_ovf), ma_ovf);
      check("a_at_max", int'(bus_a.o_at_max), int'(ma_cnt >= int'(bus_a.mod_max)));
      check("a_at_zero", int'(bus_a.o_at_zero), int'(ma_cnt == 0));
    end
    if (vb != 0) begin
      check("b_count", int'(bus_b.o_count), mb_cnt);
      check("b_tc", int'(bus_b.o_tc), mb_tc);
      check("b_ovf", int'(bus_b.o_ovf), mb_ovf);
      check("b_at_max", int'(bus_b.o_at_max), int'(mb_cnt >= int'(bus_b.mod_max)));
      check("b_at_zero", int'(bus_b.o_at_zero), int'(mb_cnt == 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic ud, input logic ld, input int lv,
                       input int mm, input logic sat, input logic clr);
    bus_a.count_en = en; bus_a.up_dn = ud; bus_a.load = ld;
    bus_a.load_val = 8'(lv); bus_a.mod_max = 8'(mm);
    bus_a.sat_mode = sat; bus_a.clr_ovf = clr;
  endtask

  task automatic set_b(input logic en, input logic ud, input logic ld, input int lv,
                       input int mm, input logic sat, input logic clr);
    bus_b.count_en = en; bus_b.up_dn = ud; bus_b.load = ld;
    bus_b.load_val = 4'(lv); bus_b.mod_max = 4'(mm);
    bus_b.sat_mode = sat; bus_b.clr_ovf = clr;
  endtask

  int pulses;

  initial begin
    set_a(0, 0, 0, 0, 0, 0, 0);
    set_b(0, 0, 0, 0, 0, 0, 0);
    tick();
    check("a_reset_count", int'(bus_a.o_count), 0);
    check("b_reset_count", int'(bus_b.o_count), 3);
    check("a_reset_ovf", int'(bus_a.o_ovf), 0);
    resetn_a = 1'b1;

    // Up, wrap, mod 9, 12 steps.
    set_a(1, 1, 0, 0, 9, 0, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(bus_a.o_tc);
      if (i == 9) check("t1_wrap_tc", int'(bus_a.o_tc), 1);
    end
    check("t1_count", int'(bus_a.o_count), 2);
    check("t1_pulses", pulses, 1);
    check("t1_ovf", int'(bus_a.o_ovf), 1);

    // Up, saturate, mod 9; clear during and after saturation.
    set_a(0, 1, 1, 0, 9, 1, 1);
    tick();
    check("t2_clr_ovf", int'(bus_a.o_ovf), 0);
    set_a(1, 1, 0, 0, 9, 1, 0);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      pulses += int'(bus_a.o_tc);
    end
    check("t2_count", int'(bus_a.o_count), 9);
    check("t2_pulses", pulses, 3);
    set_a(1, 1, 0, 0, 9, 1, 1);
    tick();
    check("t2_set_wins", int'(bus_a.o_ovf), 1);
    set_a(0, 1, 0, 0, 9, 1, 1);
    tick();
    check("t2_ovf_cleared", int'(bus_a.o_ovf), 0);
    check("t2_tc_low", int'(bus_a.o_tc), 0);

    // Down, wrap, mod 5; load beats count_en.
    set_a(1, 0, 1, 2, 5, 0, 0);
    tick();
    check("t3_load", int'(bus_a.o_count), 2);
    set_a(1, 0, 0, 0, 5, 0, 0);
    tick(); tick(); tick();
    check("t3_wrap_count", int'(bus_a.o_count), 5);
    check("t3_wrap_tc", int'(bus_a.o_tc), 1);
    tick();
    check("t3_count", int'(bus_a.o_count), 4);
    check("t3_tc_low", int'(bus_a.o_tc), 0);

    // Out-of-range loaded value.
    set_a(0, 1, 1, 200, 100, 0, 0);
    tick();
    check("t4_at_max_200", int'(bus_a.o_at_max), 1);
    set_a(1, 1, 0, 0, 100, 0, 0);
    tick();
    check("t4_up_count", int'(bus_a.o_count), 0);
    check("t4_up_tc", int'(bus_a.o_tc), 1);
    set_a(0, 0, 1, 200, 100, 0, 0);
    tick();
    set_a(1, 0, 0, 0, 100, 0, 0);
    tick();
    check("t4_down_count", int'(bus_a.o_count), 100);
    check("t4_down_tc", int'(bus_a.o_tc), 0);
    check("t4_at_max_100", int'(bus_a.o_at_max), 1);

    // mod_max = 0 corner cases.
    set_a(0, 0, 1, 5, 0, 0, 0);
    tick();
    set_a(1, 0, 0, 0, 0, 0, 0);
    tick();
    check("m0_down_count", int'(bus_a.o_count), 0);
    check("m0_down_tc", int'(bus_a.o_tc), 0);
    tick();
    check("m0_zero_tc", int'(bus_a.o_tc), 1);
    check("m0_at_zero", int'(bus_a.o_at_zero), 1);
    set_a(1, 1, 0, 0, 0, 1, 0);
    tick();
    check("m0_up_sat_count", int'(bus_a.o_count), 0);
    check("m0_up_sat_tc", int'(bus_a.o_tc), 1);
    set_a(0, 1, 0, 0, 9, 0, 0);

    // Reset mid-count on the 4-bit, RESET_VAL=3 instance.
    resetn_b = 1'b1;
    set_b(0, 1, 1, 15, 15, 0, 0);
    tick();
    set_b(1, 1, 0, 0, 15, 0, 0);
    tick();
    check("t5_pre_ovf", int'(bus_b.o_ovf), 1);
    set_b(0, 1, 1, 7, 15, 0, 0);
    tick();
    check("t5_count7", int'(bus_b.o_count), 7);
    resetn_b = 1'b0;
    set_b(1, 1, 1, 9, 15, 0, 0);
    tick();
    check("t5_reset_count", int'(bus_b.o_count), 3);
    check("t5_reset_tc", int'(bus_b.o_tc), 0);
    check("t5_reset_ovf", int'(bus_b.o_ovf), 0);
    resetn_b = 1'b1;
    set_b(1, 1, 0, 0, 15, 0, 0);
    tick();
    check("t5_resume", int'(bus_b.o_count), 4);

    // Full-range 4-bit wrap.
    set_b(0, 1, 1, 0, 15, 0, 0);
    tick();
    set_b(1, 1, 0, 0, 15, 0, 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      pulses += int'(bus_b.o_tc);
    end
    check("t6_count", int'(bus_b.o_count), 4);
    check("t6_pulses", pulses, 1);

    set_b(0, 1, 0, 0, 15, 0, 0);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/counter_updown_mod.md
Name: counter_updown_mod

Overview:
Parametrised successor to the team's basic up-counter. Adds selectable up/down direction, a synchronous parallel load and a run-time programmable modulus. Boundary handling is either wrap or saturate, with a terminal-event pulse and a sticky overflow flag. Intended as the general-purpose event/timer counter in the counter library.

Parameters:
WIDTH, 8, counter width in bits (>=2)
RESET_VAL, 0, value loaded into o_count on reset (must be <= 2^WIDTH-1)

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  synchronous active-low reset
count_en  input  1  advance counter by one step this cycle
up_dn  input  1  direction: 1 = up, 0 = down
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load
mod_max  input  WIDTH  terminal value; count range is 0..mod_max
sat_mode  input  1  0 = wrap at boundary, 1 = saturate at boundary
clr_ovf  input  1  clear sticky overflow flag
o_count  output  WIDTH  current count (registered)
o_tc  output  1  one-cycle terminal-event pulse (registered)
o_ovf  output  1  sticky boundary-event flag (registered)
o_at_max  output  1  combinational: o_count >= mod_max
o_at_zero  output  1  combinational: o_count == 0

Behaviour:
- Reset: clock is clk; reset is synchronous and active-low (resetn sampled on clk rising edge). resetn=0 -> o_count=RESET_VAL, o_tc=0, o_ovf=0 on that edge; resetn has priority over every other input.
- Priority when resetn=1: load > count_en > hold.
- load=1: o_count <= load_val, no range check (may exceed mod_max); o_tc <= 0; o_ovf unchanged except clr_ovf.
- count_en=1, load=0, up_dn=1:
  - o_count < mod_max -> o_count+1.
  - o_count >= mod_max -> boundary event: wrap mode -> 0; sat mode -> mod_max (clamps an out-of-range value down).
- count_en=1, load=0, up_dn=0:
  - o_count > mod_max -> o_count <= mod_max, no boundary event.
  - 0 < o_count <= mod_max -> o_count-1.
  - o_count == 0 -> boundary event: wrap mode -> mod_max; sat mode -> 0.
- count_en=0, load=0: o_count holds.
- Boundary event: o_tc=1 for exactly the cycle after the event edge, 0 otherwise. In sat mode, each enabled cycle pressing against the boundary is a new event, so o_tc stays high continuously.
- o_ovf: set on any boundary event; cleared by clr_ovf=1; event and clr_ovf in the same cycle -> o_ovf=1 (set wins).
- mod_max=0:
  - up or down enabled step from 0 is always a boundary event; count stays 0 in both modes.
  - From a loaded nonzero value, up -> 0 (wrap) / 0 (sat); down -> 0 with no event.
- mod_max changes mid-count: takes effect on the next edge using the rules above.
- Arithmetic is WIDTH-bit unsigned; no intermediate carry is exposed. mod_max = 2^WIDTH-1 gives natural full-range wrap.
- o_at_max and o_at_zero are derived combinationally from o_count and mod_max, with no added latency.

Test Plan:
1. WIDTH=8, RESET_VAL=0, mod_max=9, wrap, up, count_en=1 for 12 cycles -> o_count 1..9,0,1,2; o_tc high only in the cycle o_count shows 0; o_ovf=1 thereafter.
2. mod_max=9, sat_mode=1, up, count_en=1 for 12 cycles -> o_count 1..9 then holds 9; o_tc high in each of the last 3 cycles; clr_ovf pulse while still saturating -> o_ovf stays 1; drop count_en, pulse clr_ovf -> o_ovf=0.
3. Down, wrap, mod_max=5, load_val=2 with load=1 and count_en=1 together -> o_count=2 (load wins), then 1,0,5,4; o_tc pulses once, when 5 appears.
4. load_val=200, mod_max=100: up wrap step -> 0 with o_tc; reload 200, down step -> 100 with no o_tc; o_at_max=1 at 200 and at 100.
5. Reset mid-count at o_count=7, RESET_VAL=3: drop resetn for one edge with count_en=1, load=1 -> o_count=3, o_tc=0, o_ovf=0 on that edge; counting resumes next edge.
6. WIDTH=4, mod_max=15, up wrap, 20 enabled cycles -> full-range wrap 15->0 once, one o_tc pulse, o_count ends at 4.
